// File: rtl/fat32_pkg.sv
// fat32_pkg: shared FAT32 constants and the sector generator FSM state type.
package fat32_pkg;
    localparam logic [31:0] FAT32_EOC                = 32'h0FFFFFFF;
    localparam logic [31:0] FAT32_MEDIA              = 32'h0FFFFFF8;
    localparam int          FAT32_ENTRIES_PER_SECTOR = 128;
    typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;
endpackage

// File: rtl/fat32_entry_calc.sv
// fat32_entry_calc: combinational value of FAT32 entry n for one contiguous chain.
// Ports: n (39 b entry number), first_cluster, chain_end (first_cluster + count, 33 b), entry (32 b value).
// Optional FAT32_RESERVED_ENTRIES_EN: entries 0 and 1 carry the media/EOC markers instead of the general rule.
module fat32_entry_calc
    import fat32_pkg::*;
(
    input  logic [38:0] n,
    input  logic [31:0] first_cluster,
    input  logic [32:0] chain_end,
    output logic [31:0] entry
);
    logic in_chain;
    logic last;
    logic [31:0] chain_val;
    // n < chain_end with chain_end == first_cluster excludes everything, so an empty chain needs no special case
    assign in_chain  = (n >= {7'd0, first_cluster}) && (n < {6'd0, chain_end});
    assign last      = (n + 39'd1) == {6'd0, chain_end};
    // entries past 2^32 do not exist in FAT32 and read as free
    assign chain_val = (|n[38:32]) ? 32'd0 : in_chain ? (last ? FAT32_EOC : n[31:0] + 32'd1) : 32'd0;
`ifdef FAT32_RESERVED_ENTRIES_EN
    assign entry = (n == 39'd0) ? FAT32_MEDIA : (n == 39'd1) ? FAT32_EOC : chain_val;
`else
    assign entry = chain_val;
`endif
endmodule

// File: rtl/fat32_chain_sector_gen.sv
// fat32_chain_sector_gen: streams one 512-byte FAT32 table sector describing a single contiguous cluster chain.
// Ports: sys_clk/sys_rst (async active-high); start + sector_index/first_cluster/cluster_count request;
//        busy; byte_valid/byte_data/byte_addr/byte_ready little-endian byte stream; done pulse after byte 511.
// Optional FAT32_RESERVED_ENTRIES_EN (in fat32_entry_calc) enables the reserved entries 0 and 1.
module fat32_chain_sector_gen
    import fat32_pkg::*;
#(
    parameter int SECTOR_BYTES = 512,
    parameter int ADDR_W       = 10
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic [31:0]       sector_index,
    input  logic [31:0]       first_cluster,
    input  logic [31:0]       cluster_count,
    output logic              busy,
    output logic              byte_valid,
    output logic [7:0]        byte_data,
    output logic [ADDR_W-1:0] byte_addr,
    input  logic              byte_ready,
    output logic              done
);
    state_t      state, state_nxt;
    logic [31:0] sidx_q, fc_q, entry_q, entry_w;
    logic [32:0] end_q;
    logic [8:0]  cnt;
    logic [6:0]  idx_nxt;
    logic        xfer;
    assign xfer = byte_valid & byte_ready;
    // LOAD fetches entry 0; in EMIT the following entry is fetched so it is ready when its byte 0 is presented
    assign idx_nxt = (state == LOAD) ? 7'd0 : cnt[8:2] + 7'd1;
    fat32_entry_calc u_calc (
        .n             ({sidx_q, idx_nxt}),
        .first_cluster (fc_q),
        .chain_end     (end_q),
        .entry         (entry_w)
    );
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? LOAD : IDLE;
            LOAD:    state_nxt = EMIT;
            EMIT:    state_nxt = (xfer && cnt == 9'(SECTOR_BYTES - 1)) ? DONE : EMIT;
            default: state_nxt = IDLE;
        endcase
    end
    assign busy       = state != IDLE;
    assign byte_valid = state == EMIT;
    assign done       = state == DONE;
    assign byte_data  = byte_valid ? entry_q[{cnt[1:0], 3'b000} +: 8] : 8'h00;
    assign byte_addr  = ADDR_W'(cnt);
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= IDLE;
            sidx_q  <= '0;
            fc_q    <= '0;
            end_q   <= '0;
            cnt     <= '0;
            entry_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                sidx_q <= sector_index;
                fc_q   <= first_cluster;
                end_q  <= {1'b0, first_cluster} + {1'b0, cluster_count};
            end
            if (state == LOAD) begin
                cnt     <= '0;
                entry_q <= entry_w;
            end else if (xfer) begin
                cnt <= cnt + 9'd1;
                if (cnt[1:0] == 2'd3) entry_q <= entry_w;
            end
        end
    end
endmodule

// File: doc/fat32_chain_sector_gen.md
# fat32_chain_sector_gen

Generates the byte stream of one 512-byte FAT32 allocation-table sector describing a single contiguous cluster chain, for the SD-card write path. The BPB parser supplies the FAT location; this block is the writer-side counterpart. It produces the table contents the FAT region must hold after a file is laid down, so the card remains readable by a host. Bytes leave in address order through a valid/ready handshake into the sector buffer or SD write engine.

## Interface
- SECTOR_BYTES, 512, bytes per sector; fixed at 512 for FAT32.
- ADDR_W, 10, width of `byte_addr`.
- sys_clk  in  1  single clock; all logic on rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- sector_index  in  32  sector offset within the FAT region; latched on accepted `start`.
- first_cluster  in  32  first cluster of the chain; latched on accepted `start`.
- cluster_count  in  32  chain length in clusters; latched on accepted `start`.
- busy  out  1  high from the cycle after accepted `start` through DONE.
- byte_valid  out  1  `byte_data`/`byte_addr` are valid.
- byte_data  out  8  sector byte.
- byte_addr  out  ADDR_W  byte offset 0..511 within the sector.
- byte_ready  in  1  consumer accepts the byte when `byte_valid & byte_ready`.
- done  out  1  one-cycle pulse after byte 511 is accepted.

## Operation
- Each sector holds 128 entries of 4 bytes. Entry number n = sector_index*128 + (byte_addr>>2). Bytes are little-endian: byte_addr[1:0]=0 is entry bits [7:0].
- Let end = first_cluster + cluster_count, computed at 33 bits; no wrap.
- Entry value:
  - 0x0FFFFFF8 for n=0.
  - 0x0FFFFFFF for n=1.
  - n+1 for first_cluster ≤ n < end−1.
  - 0x0FFFFFFF (EOC) for n = end−1.
  - 0x00000000 otherwise.
- `cluster_count`=0 means no chain: all entries are 0 except n=0 and n=1.
- `sector_index*128` is computed at 39 bits, so n never wraps. Entries with n ≥ 2^32 are 0.
- FSM states:
  - IDLE: waits for `start`.
  - LOAD: latches inputs, clears the byte counter, precomputes entry n.
  - EMIT: streams bytes.
  - DONE: asserts `done`, then returns to IDLE.
- Transitions: IDLE→LOAD on `start`. LOAD→EMIT unconditionally. In EMIT, stay until byte 511 is accepted, then go to DONE. DONE→IDLE unconditionally.
- `start` is ignored while not in IDLE. It is not queued.
- Inputs may change after the `start` cycle without effect.

## Timing
- Reset values: `busy`=0, `byte_valid`=0, `byte_data`=0x00, `byte_addr`=0, `done`=0. The FSM resets to IDLE.
- `start` high in IDLE at edge k:
  - `busy`=1 from k+1.
  - `byte_valid`=1 with byte 0 from k+2.
- While `byte_valid`=1 and `byte_ready`=0, `byte_data`/`byte_addr` are held stable.
- With `byte_ready` constantly 1, one byte is transferred per cycle. 512 bytes take 512 cycles.
- After the byte-511 transfer at edge m:
  - `byte_valid`=0 and `done`=1 during cycle m+1.
  - `busy` falls at m+2.
- A `start` in the `done` cycle is ignored. The earliest accepted start is at m+2.
- Reset asserted mid-stream aborts immediately: all outputs return to reset values and no `done` is produced.
- The next entry value is registered before its byte 0 is presented. There is no combinational path from `byte_ready` to `byte_data`.

## Configuration
- FAT32_RESERVED_ENTRIES_EN:
  - Defined: entries n=0 and n=1 carry 0x0FFFFFF8 and 0x0FFFFFFF as above.
  - Undefined: entries 0 and 1 follow the general rule and therefore read 0. This mode is for regenerating non-first FAT sectors with smaller logic, by dropping the n<2 comparators.

## Structure
- Package `fat32_pkg` holds:
  - FAT32_EOC=32'h0FFFFFFF, FAT32_MEDIA=32'h0FFFFFF8, FAT32_ENTRIES_PER_SECTOR=128.
  - The FSM state enum (IDLE, LOAD, EMIT, DONE).
- Sub-module `fat32_entry_calc`: combinational. Inputs are n (39 b), first_cluster and end; output is the 32-bit entry value. It is instantiated once, and its output is registered in the top.

## Test plan
- sector_index=0, first_cluster=2, cluster_count=3, ready=1 → bytes 0..15 = F8 FF FF 0F, FF FF FF 0F, 03 00 00 00, 04 00 00 00. Bytes 16..19 = FF FF FF 0F. Bytes 20..511 = 00. `done` is pulsed once, 514 cycles after `start`.
- sector_index=1, first_cluster=100, cluster_count=200 → entry 0 of the sector (n=128) = 129, i.e. bytes 0..3 = 81 00 00 00. Entry 127 (n=255) = 256 = 00 01 00 00.
- Random `byte_ready` backpressure, 30% duty → data/addr stay stable while stalled. The 512 bytes match a golden model and `byte_addr` is strictly incrementing.
- `start` pulsed during EMIT and during the `done` cycle → ignored. Exactly one `done` is produced.
- Reset asserted at byte 200 → outputs are at reset values on the next sample and there is no `done`. A new `start` then produces a full sector from byte 0.
- cluster_count=0, sector_index=0xFFFFFFFF → all 512 bytes are 00 and no overflow artifacts appear. The same test is repeated with FAT32_RESERVED_ENTRIES_EN undefined on sector 0, expecting bytes 0..7 = 00.
